// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit-type encoding, flit-type decode
// helpers and the wormhole arbitration state type. Imported by the injection
// scheduler and by the router-side allocators that reuse rr_arbiter.
package noc_pkg;

    localparam int FLIT_W = 20;

    // Flit type lives in the two MSBs of every flit.
    localparam logic [1:0] FT_HEAD   = 2'b10;
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Extract the type field of a flit.
    function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: 2];
    endfunction

    // True for flits that open a packet (head, or single head+tail).
    function automatic logic is_head(input logic [1:0] ft);
        logic res;
        case (ft)
            FT_HEAD, FT_SINGLE: res = 1'b1;
            FT_BODY, FT_TAIL:   res = 1'b0;
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector, one bit per requester
//   ptr : highest-priority index; search runs ptr, ptr+1, ... wrapping
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted requester (0 when none)
//   any : at least one request present
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the requesters in priority order; the first hit claims the grant.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int  j;
            logic take;
            j      = (int'(ptr) + k) % N;
            take   = req[j] & ~any;
            gnt[j] = gnt[j] | take;
            idx    = take ? IW'(j) : idx;
            any    = any | take;
        end
    end

endmodule

// File: rtl/inject_scheduler.sv
// Shares the router local-injection port between NUM_SRC on-node sources.
// A round-robin wormhole arbiter grants whole packets; a credit counter that
// mirrors the router's local input buffer gates every transfer.
//   clk, RST         : clock, asynchronous active-low reset
//   src_flit/valid   : per-source flit bundles (source i at [i*FLIT_W +: FLIT_W])
//   src_ready        : per-source accept strobe (combinational)
//   credit_in        : one router buffer slot freed (one-cycle pulse)
//   dataout/out_valid: registered flit towards the router
//   grant_id         : owner of the most recently started packet
//   busy             : a multi-flit packet is in progress
//   credit_err       : sticky, credit returned while the counter was full
module inject_scheduler
    import noc_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int CREDIT_MAX = 4
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic [NUM_SRC*FLIT_W-1:0] src_flit,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      credit_in,
    output logic [FLIT_W-1:0]         dataout,
    output logic                      out_valid,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      credit_err
);

    localparam int              IW        = $clog2(NUM_SRC);
    localparam logic [3:0]      CRED_FULL = 4'(CREDIT_MAX);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_SRC - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [3:0]          cred_q, cred_d;
    logic                cred_err_q, cred_err_d;
    logic [FLIT_W-1:0]   dout_q, dout_d;
    logic                oval_q, oval_d;

    logic [NUM_SRC-1:0]  elig_s;
    logic [NUM_SRC-1:0]  arb_gnt_s;
    logic [IW-1:0]       arb_idx_s;
    logic                arb_any_s;
    logic [NUM_SRC-1:0]  ready_s;
    logic                cred_ok_s;
    logic                xfer_s;
    logic [IW-1:0]       sel_idx_s;
    logic [FLIT_W-1:0]   sel_flit_s;
    logic [1:0]          sel_type_s;

    // Round-robin successor of a source index.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? IW'(0) : i + IW'(1);
    endfunction

    // Only packet-opening flits may compete for an idle port.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig_s[i] = src_valid[i] & is_head(flit_type(src_flit[i*FLIT_W +: FLIT_W]));
        end
    end

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req (elig_s),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    assign cred_ok_s = (cred_q != 4'd0);

    // Ready generation and selection of the flit being transferred.
    always_comb begin
        ready_s = '0;
        case (state_q)
            IDLE:    ready_s = (cred_ok_s && arb_any_s) ? arb_gnt_s : '0;
            LOCKED:  ready_s[owner_q] = cred_ok_s;
            default: ready_s = '0;
        endcase
        sel_idx_s  = (state_q == LOCKED) ? owner_q : arb_idx_s;
        sel_flit_s = src_flit[int'(sel_idx_s)*FLIT_W +: FLIT_W];
        sel_type_s = flit_type(sel_flit_s);
        xfer_s     = |(src_valid & ready_s);
    end

    // Packet-level state: lock on head, release on tail, advance the pointer.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    grant_d = arb_idx_s;
                    if (sel_type_s == FT_HEAD) begin
                        state_d = LOCKED;
                        owner_d = arb_idx_s;
                    end else begin
                        rr_ptr_d = next_idx(arb_idx_s);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                // Only the tail type matters once a packet owns the port.
                if (xfer_s && (sel_type_s == FT_TAIL)) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(owner_q);
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit mirror of the router buffer and the output register inputs.
    always_comb begin
        cred_d     = cred_q;
        cred_err_d = cred_err_q;
        case ({xfer_s, credit_in})
            2'b10: cred_d = cred_q - 4'd1;
            2'b01: begin
                if (cred_q == CRED_FULL) begin
                    cred_err_d = 1'b1;
                end else begin
                    cred_d = cred_q + 4'd1;
                end
            end
            default: cred_d = cred_q;
        endcase
        dout_d = xfer_s ? sel_flit_s : dout_q;
        oval_d = xfer_s;
    end

    // State register; reset abandons any partial packet.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cred_q     <= CRED_FULL;
            cred_err_q <= 1'b0;
            dout_q     <= '0;
            oval_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cred_q     <= cred_d;
            cred_err_q <= cred_err_d;
            dout_q     <= dout_d;
            oval_q     <= oval_d;
        end
    end

    // Ready is held low while reset is applied, whatever the sources present.
    assign src_ready  = ready_s & {NUM_SRC{RST}};
    assign dataout    = dout_q;
    assign out_valid  = oval_q;
    assign grant_id   = 3'(grant_q);
    assign busy       = (state_q == LOCKED);
    assign credit_err = cred_err_q;

endmodule

// File: tb/tb_inject_scheduler.sv
module tb_inject_scheduler;

    localparam logic [1:0] H = 2'b10;
    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] T = 2'b01;
    localparam logic [1:0] S = 2'b11;

    logic        clk;
    logic        RST;
    logic [79:0] src_flit;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic        credit_in;
    logic [19:0] dataout;
    logic        out_valid;
    logic [2:0]  grant_id;
    logic        busy;
    logic        credit_err;

    int total = 0;
    int bad   = 0;

    logic [19:0] sq [4][$];
    logic [19:0] out_log [$];

    // reference model state
    int          m_cred, m_ptr, m_owner, m_gid;
    bit          m_locked, m_err, m_ov;
    logic [19:0] m_dout;

    inject_scheduler #(.NUM_SRC(4), .CREDIT_MAX(4)) dut (
        .clk        (clk),
        .RST        (RST),
        .src_flit   (src_flit),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .credit_in  (credit_in),
        .dataout    (dataout),
        .out_valid  (out_valid),
        .grant_id   (grant_id),
        .busy       (busy),
        .credit_err (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] mk(input logic [1:0] t, input int s, input int n);
        return {t, 10'd0, 4'(s), 4'(n)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cred = 4; m_ptr = 0; m_owner = 0; m_gid = 0;
        m_locked = 0; m_err = 0; m_ov = 0; m_dout = '0;
    endtask

    // Per-cycle compare against the reference model, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!RST) begin
                chk("rst_ready", 32'(src_ready), 32'd0);
                chk("rst_oval", 32'(out_valid), 32'd0);
                chk("rst_dout", 32'(dataout), 32'd0);
                model_reset();
            end else begin
                logic [3:0]  exp_ready;
                logic [19:0] f;
                logic [1:0]  t;
                int          sel;
                bit          xfer;
                exp_ready = '0;
                sel = -1;
                if (!m_locked) begin
                    for (int k = 0; k < 4; k++) begin
                        int j;
                        logic [1:0] tj;
                        j  = (m_ptr + k) % 4;
                        tj = src_flit[j*20+18 +: 2];
                        if (sel < 0 && src_valid[j] && (tj == H || tj == S)) sel = j;
                    end
                    if (sel >= 0 && m_cred > 0) exp_ready[sel] = 1'b1;
                end else begin
                    sel = m_owner;
                    if (m_cred > 0) exp_ready[sel] = 1'b1;
                end
                chk("ready", 32'(src_ready), 32'(exp_ready));
                chk("out_valid", 32'(out_valid), 32'(m_ov));
                chk("dataout", 32'(dataout), 32'(m_dout));
                chk("grant_id", 32'(grant_id), 32'(m_gid));
                chk("busy", 32'(busy), 32'(m_locked));
                chk("credit_err", 32'(credit_err), 32'(m_err));
                if (out_valid) out_log.push_back(dataout);

                xfer = |(src_valid & exp_ready);
                f = '0;
                t = 2'b00;
                if (xfer) begin
                    f = src_flit[sel*20 +: 20];
                    t = f[19:18];
                    m_dout = f;
                end
                m_ov = xfer;
                if (xfer && !m_locked) begin
                    m_gid = sel;
                    if (t == H) begin
                        m_locked = 1; m_owner = sel;
                    end else begin
                        m_ptr = (sel + 1) % 4;
                    end
                end else if (xfer && m_locked && t == T) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % 4;
                end
                if (xfer && !credit_in) m_cred--;
                else if (!xfer && credit_in) begin
                    if (m_cred == 4) m_err = 1;
                    else m_cred++;
                end
            end
        end
    end

    task automatic present();
        for (int i = 0; i < 4; i++) begin
            if (sq[i].size() > 0) begin
                src_valid[i] = 1'b1;
                src_flit[i*20 +: 20] = sq[i][0];
            end else begin
                src_valid[i] = 1'b0;
                src_flit[i*20 +: 20] = '0;
            end
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic cr);
        logic [3:0] acc;
        credit_in = cr;
        @(negedge clk);
        acc = src_valid & src_ready;
        @(posedge clk);
        #1;
        credit_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        end
        present();
    endtask

    initial begin
        RST = 1'b0;
        src_flit = '0;
        src_valid = '0;
        credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // ready must stay low during reset even with a head presented
        src_valid = 4'b0001;
        src_flit[19:0] = mk(H, 0, 0);
        #1;
        chk("reset_ready_gated", 32'(src_ready), 32'd0);
        chk("reset_grant", 32'(grant_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(credit_err), 32'd0);
        src_valid = '0;
        src_flit = '0;
        RST = 1'b1;
        @(posedge clk);
        #1;

        // fairness: every source offers singles; credit returned every cycle
        for (int n = 0; n < 3; n++)
            for (int s = 0; s < 4; s++) sq[s].push_back(mk(S, s, n));
        present();
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1);
            chk("fair_grant", 32'(grant_id), 32'(k % 4));
            chk("fair_flit", 32'(dataout), 32'(mk(S, k % 4, k / 4)));
        end
        cycle(1'b0);

        // single source: four-flit packet drains all credit
        sq[0].push_back(mk(H, 0, 1));
        sq[0].push_back(mk(B, 0, 2));
        sq[0].push_back(mk(B, 0, 3));
        sq[0].push_back(mk(T, 0, 4));
        present();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0);
            chk("single_oval", 32'(out_valid), 32'd1);
            chk("single_flit", 32'(dataout[3:0]), 32'(k + 1));
        end
        sq[0].push_back(mk(S, 0, 5));
        present();
        #1;
        chk("single_no_cred", 32'(src_ready[0]), 32'd0);
        credit_in = 1'b1;
        #1;
        chk("ready_ignores_credit_in", 32'(src_ready[0]), 32'd0);
        cycle(1'b1);
        chk("single_cred_back", 32'(src_ready[0]), 32'd1);
        cycle(1'b0);
        chk("single_extra_flit", 32'(dataout), 32'(mk(S, 0, 5)));
        repeat (4) cycle(1'b1);

        // wormhole lock: src1 3-flit packet, src2 head arrives one cycle later
        out_log.delete();
        sq[1].push_back(mk(H, 1, 1));
        sq[1].push_back(mk(B, 1, 2));
        sq[1].push_back(mk(T, 1, 3));
        present();
        cycle(1'b0);
        sq[2].push_back(mk(H, 2, 1));
        sq[2].push_back(mk(T, 2, 2));
        present();
        chk("worm_lock_a", 32'(src_ready[2]), 32'd0);
        cycle(1'b0);
        chk("worm_lock_b", 32'(src_ready[2]), 32'd0);
        cycle(1'b0);
        chk("worm_release", 32'(src_ready[2]), 32'd1);
        cycle(1'b1);
        chk("worm_xfer_and_credit", 32'(src_ready[2]), 32'd1);
        cycle(1'b0);
        cycle(1'b0);
        chk("worm_count", 32'(out_log.size()), 32'd5);
        if (out_log.size() == 5) begin
            chk("worm_order", {out_log[0][7:4], out_log[1][7:4], out_log[2][7:4],
                               out_log[3][7:4], out_log[4][7:4]}, 32'h11122);
        end
        repeat (4) cycle(1'b1);

        // credit boundaries
        cycle(1'b1);
        chk("overflow_err", 32'(credit_err), 32'd1);
        out_log.delete();
        for (int n = 0; n < 6; n++) sq[0].push_back(mk(S, 0, n));
        present();
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        chk("cred_hold_exhaust", 32'(src_ready[0]), 32'd0);
        cycle(1'b0);
        chk("cred_hold_count", 32'(out_log.size()), 32'd5);
        chk("err_sticky", 32'(credit_err), 32'd1);
        cycle(1'b1);
        cycle(1'b0);
        repeat (4) cycle(1'b1);

        // reset mid-packet while src3 owns the port with one credit left
        for (int n = 0; n < 5; n++) sq[3].push_back(mk((n == 0) ? H : ((n == 4) ? T : B), 3, n));
        present();
        repeat (3) cycle(1'b0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        chk("pre_reset_grant", 32'(grant_id), 32'd3);
        #2;
        RST = 1'b0;
        #1;
        chk("async_oval", 32'(out_valid), 32'd0);
        chk("async_dout", 32'(dataout), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_grant", 32'(grant_id), 32'd0);
        chk("async_ready", 32'(src_ready), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) sq[i].delete();
        sq[3].push_back(mk(B, 3, 9));
        sq[0].push_back(mk(H, 0, 1));
        sq[0].push_back(mk(T, 0, 2));
        present();
        RST = 1'b1;
        #1;
        chk("post_reset_body_refused", 32'(src_ready[3]), 32'd0);
        chk("post_reset_head_ready", 32'(src_ready[0]), 32'd1);
        chk("post_reset_err", 32'(credit_err), 32'd0);
        cycle(1'b0);
        chk("post_reset_busy", 32'(busy), 32'd1);
        chk("post_reset_grant", 32'(grant_id), 32'd0);
        chk("post_reset_flit", 32'(dataout), 32'(mk(H, 0, 1)));
        chk("post_reset_src3_blocked", 32'(src_ready[3]), 32'd0);
        cycle(1'b0);
        sq[3].delete();
        present();
        cycle(1'b0);
        chk("post_reset_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
